kara_seq_ctrl: RTL and testbench
================================

# kara_seq_ctrl

Sequencing controller that computes a 128×128 unsigned product by time-sharing a single 64×64 sub-multiplier across the four partial products (x_hi·y_hi, x_hi·y_lo, x_lo·y_hi, x_lo·y_lo). It accepts operands over a valid/ready handshake and drives the shared sub-multiplier through a start/done handshake. It accumulates the shifted partial products into a 256-bit result and returns that result over a valid/ready handshake. It is the area-reduced alternative to the four-multiplier parallel 128-bit top in the kara128 datapath.

## Interface
- MUL_LAT_MAX, 64: watchdog limit, in cycles, for one sub-multiply (start to done).
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operand request.
- in_ready  out  1  controller can accept operands.
- x, y  in  128 each  multiplicand and multiplier, unsigned.
- m_start  out  1  single-cycle start pulse to the sub-multiplier.
- m_a, m_b  out  64 each  sub-multiplier operands; registered and stable from m_start until m_done.
- m_done  in  1  single-cycle pulse from the sub-multiplier; m_p is valid in the same cycle.
- m_p  in  128  sub-multiplier product.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- z  out  256  product x·y.
- err  out  1  watchdog fired during this operation; valid with out_valid.
- busy  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE: in_ready=1.
  - ISSUE: drive m_start and the operand pair for the current index.
  - WAIT: wait for m_done.
  - OUT: hold z and out_valid until accepted.
- IDLE→ISSUE on in_valid&&in_ready. On that edge: latch x and y, clear the accumulator, set index=0, clear err.
- Product order by index, with accumulator shift:
  - 0: x[63:0]·y[63:0], shift 0.
  - 1: x[127:64]·y[63:0], shift 64.
  - 2: x[63:0]·y[127:64], shift 64.
  - 3: x[127:64]·y[127:64], shift 128.
- ISSUE→WAIT always, except for a skipped product (see Configuration).
- WAIT: on m_done, acc += {128'b0,m_p} << shift (256-bit add; the final sum cannot overflow). Then increment index. If index was 3, go to OUT; otherwise go to ISSUE.
- m_done is sampled only in WAIT. It is ignored in IDLE, ISSUE and OUT.
- Watchdog: a counter clears on entry to WAIT. If it reaches MUL_TIMEOUT... specifically, when it reaches MUL_LAT_MAX with no m_done:
  - set err;
  - treat the product as zero;
  - advance exactly as if m_done had arrived.
- OUT→IDLE on out_ready. z and err hold their values until the next accept.
- in_ready=0 in ISSUE, WAIT and OUT; there is no overlap of operations.
- Reset values: in_ready=1, m_start=0, m_a=0, m_b=0, out_valid=0, z=0, err=0, busy=0, state=IDLE.
- Reset asserted mid-operation aborts immediately to the reset values above. A sub-multiplier still in flight is the system's responsibility to reset on the same rst_n.

## Timing
- Define L as the number of cycles from the m_start cycle to the m_done cycle, with L≥1.
- Accept edge is cycle 0. First m_start is in cycle 1. Each product occupies L+1 cycles.
- out_valid rises in cycle 4L+5. Back-to-back throughput is one result per 4L+6 cycles when out_ready is tied high.
- m_start is high for exactly one cycle per issued product. m_a and m_b change only in ISSUE.
- out_valid&&out_ready in cycle t gives in_ready=1 in cycle t+1.

## Configuration
- KARA_SKIP_ZERO_EN defined:
  - In ISSUE, a product whose selected x half or y half is zero is skipped. m_start stays 0, the accumulator is unchanged, and the index advances. The controller stays in ISSUE, or goes to OUT after index 3.
  - Each skipped product costs 1 cycle.
  - x=0 gives out_valid in cycle 5.
- KARA_SKIP_ZERO_EN undefined: all four products are always issued, and latency is fixed at 4L+5.

## Structure
- Package kara_pkg holds:
  - HALF_W=64, FULL_W=128, PROD_W=256;
  - the state enum (IDLE, ISSUE, WAIT, OUT);
  - the 2-bit product index type;
  - a function returning the shift for each index.
- One sub-module, kara_acc256: a 256-bit accumulator with clear, and an add-shifted-128-bit-operand input selecting shift 0, 64 or 128.

## Test plan
- Sub-multiplier model with L=3; x=y=2^128−1 → z=2^256−2^129+1, out_valid at cycle 17, exactly 4 m_start pulses, err=0.
- x=0x1_0000000000000002 (2^64+2), y=3, skip-zero disabled → z=0x3_0000000000000006, 4 issues; with KARA_SKIP_ZERO_EN → 2 issues, 2 skip cycles.
- out_ready held low for 10 cycles after out_valid → z stable, in_ready=0, no m_start pulses; then accept → in_ready=1 on the next cycle.
- Model drops m_done on index 2 with MUL_LAT_MAX=8 → err=1, z equals the expected result minus the index-2 term, exactly one result returned.
- rst_n asserted during WAIT of index 1 → all outputs at reset values immediately. A new request with x=5, y=7 → z=35.
- Spurious m_done pulse in IDLE and in OUT → no accumulator change, z unchanged.

Source files
------------

// File: rtl/kara_pkg.sv
// Shared widths, FSM state encoding, product index type and per-index shift mapping.
// Latency: none, types and constant functions only.
// Backpressure: not applicable.
package kara_pkg;

   localparam int HALF_W = 64;
   localparam int FULL_W = 128;
   localparam int PROD_W = 256;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      OUT
   } state_t;

   // Index of the partial product being computed (0..3).
   typedef logic [1:0] pidx_t;

   // Accumulator alignment of a partial product.
   typedef enum logic [1:0] {
      SH_0,
      SH_64,
      SH_128
   } shift_t;

   // lo*lo lands at bit 0, the two cross terms at bit 64, hi*hi at bit 128.
   function automatic shift_t kara_shift(input pidx_t idx);
      shift_t s;
      case (idx)
         2'd0:    s = SH_0;
         2'd3:    s = SH_128;
         default: s = SH_64;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/kara_acc256.sv
// 256-bit accumulator adding a 128-bit operand placed at bit 0, 64 or 128.
// Latency: sum visible one cycle after add_en; clear also takes one cycle.
// Backpressure: none, accepts an add every cycle.
module kara_acc256
   import kara_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              add_en,
   input  shift_t            shift,
   input  logic [FULL_W-1:0] opnd,
   output logic [PROD_W-1:0] acc
);

   logic [PROD_W-1:0] addend;

   // Align the operand to its weight inside the 256-bit sum.
   always_comb begin
      addend = '0;
      case (shift)
         SH_64:   addend[HALF_W +: FULL_W] = opnd;
         SH_128:  addend[FULL_W +: FULL_W] = opnd;
         default: addend[0 +: FULL_W]      = opnd;
      endcase
   end

   // Clear wins over add so a new operation never inherits a stale partial sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (add_en) begin
         acc <= acc + addend;
      end
   end

endmodule

// File: rtl/kara_seq_ctrl.sv
// 128x128 multiply by sequencing four 64x64 partial products through one shared sub-multiplier.
// Latency: 4L+5 cycles accept-to-out_valid; with KARA_SKIP_ZERO_EN a product with a zero half costs 1 cycle.
// Backpressure: in_ready only in IDLE; result and err held in OUT until out_ready.
module kara_seq_ctrl
   import kara_pkg::*;
#(
   parameter int MUL_LAT_MAX = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [FULL_W-1:0] x,
   input  logic [FULL_W-1:0] y,
   output logic              m_start,
   output logic [HALF_W-1:0] m_a,
   output logic [HALF_W-1:0] m_b,
   input  logic              m_done,
   input  logic [FULL_W-1:0] m_p,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] z,
   output logic              err,
   output logic              busy
);

   localparam int CNT_W = $clog2(MUL_LAT_MAX + 1);

   state_t            state, state_n;
   pidx_t             idx, idx_nx;
   logic [FULL_W-1:0] xr, yr;
   logic [CNT_W-1:0]  wd_cnt;
   logic              accept, adv, timeout, skip;
   logic [PROD_W-1:0] acc;

   // Index bit 0 picks the x half, bit 1 picks the y half.
   function automatic logic [HALF_W-1:0] half_of(input logic [FULL_W-1:0] v, input logic hi);
      return hi ? v[FULL_W-1:HALF_W] : v[HALF_W-1:0];
   endfunction

   assign idx_nx  = idx + 2'd1;
   assign accept  = (state == IDLE) && in_valid;
   // Fires on the last allowed WAIT cycle, so a done arriving MUL_LAT_MAX cycles after start still counts.
   assign timeout = (state == WAIT) && !m_done && (wd_cnt == CNT_W'(MUL_LAT_MAX - 1));

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == OUT);
   assign busy      = (state != IDLE);
   assign z         = acc;

   // Next-state decode; a timeout advances exactly like a done but contributes nothing to the sum.
   always_comb begin
      state_n = state;
      adv     = 1'b0;
      m_start = 1'b0;
      skip    = 1'b0;
`ifdef KARA_SKIP_ZERO_EN
      skip    = (m_a == '0) || (m_b == '0);
`endif
      case (state)
         IDLE: begin
            if (in_valid) state_n = ISSUE;
         end
         ISSUE: begin
            if (skip) begin
               adv     = 1'b1;
               state_n = (idx == 2'd3) ? OUT : ISSUE;
            end else begin
               m_start = 1'b1;
               state_n = WAIT;
            end
         end
         WAIT: begin
            if (m_done || timeout) begin
               adv     = 1'b1;
               state_n = (idx == 2'd3) ? OUT : ISSUE;
            end
         end
         OUT: begin
            if (out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // State register and watchdog; the counter sits at zero outside WAIT so it restarts on every entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         wd_cnt <= '0;
      end else begin
         state  <= state_n;
         wd_cnt <= (state == WAIT) ? wd_cnt + CNT_W'(1) : '0;
      end
   end

   // Operand capture, index stepping and error flag; m_a/m_b reload only on the edge into ISSUE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xr  <= '0;
         yr  <= '0;
         idx <= '0;
         m_a <= '0;
         m_b <= '0;
         err <= 1'b0;
      end else if (accept) begin
         xr  <= x;
         yr  <= y;
         idx <= '0;
         m_a <= x[HALF_W-1:0];
         m_b <= y[HALF_W-1:0];
         err <= 1'b0;
      end else begin
         if (adv) begin
            idx <= idx_nx;
            if (state_n == ISSUE) begin
               m_a <= half_of(xr, idx_nx[0]);
               m_b <= half_of(yr, idx_nx[1]);
            end
         end
         if (timeout) err <= 1'b1;
      end
   end

   kara_acc256 u_acc (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (accept),
      .add_en ((state == WAIT) && m_done),
      .shift  (kara_shift(idx)),
      .opnd   (m_p),
      .acc    (acc)
   );

endmodule

// File: tb/tb_kara_seq_ctrl.sv
// Bench for kara_seq_ctrl with a behavioural sub-multiplier model, vector table and random operands.
// Latency: checks accept-to-out_valid cycle counts against the timing rules.
// Backpressure: exercises out_ready held low and spurious m_done pulses.
`timescale 1ns/1ps
module tb_kara_seq_ctrl;

   localparam int LAT_MAX = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b1;
   logic [127:0] x = '0;
   logic [127:0] y = '0;
   logic         m_done = 1'b0;
   logic [127:0] m_p = '0;
   logic         in_ready, m_start, out_valid, err, busy;
   logic [63:0]  m_a, m_b;
   logic [255:0] z;

   kara_seq_ctrl #(.MUL_LAT_MAX(LAT_MAX)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .m_start   (m_start),
      .m_a       (m_a),
      .m_b       (m_b),
      .m_done    (m_done),
      .m_p       (m_p),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .z         (z),
      .err       (err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // ---------------- sub-multiplier model ----------------
   int          mdl_lat = 3;
   int          mdl_drop = -1;
   logic        spur_done = 1'b0;
   int          start_cyc = 0;
   int          m_iss = 0;
   int          m_left = 0;
   logic        m_pend = 1'b0;
   logic        m_drop = 1'b0;
   logic [63:0] m_pa = '0;
   logic [63:0] m_pb = '0;

   initial begin
      forever begin
         @(negedge clk);
         m_done = spur_done;
         m_p    = spur_done ? '1 : '0;
         if (!rst_n) m_pend = 1'b0;
         if (!busy) m_iss = 0;
         if (rst_n && m_pend) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_pend = 1'b0;
               if (!m_drop) begin
                  m_done = 1'b1;
                  m_p    = {64'b0, m_pa} * {64'b0, m_pb};
               end
            end
         end else if (rst_n && m_start) begin
            m_pend = 1'b1;
            m_left = mdl_lat;
            m_pa   = m_a;
            m_pb   = m_b;
            m_drop = (m_iss == mdl_drop);
            m_iss  = m_iss + 1;
         end
      end
   end

   always @(negedge clk) if (m_start) start_cyc <= start_cyc + 1;

   // ---------------- checking helpers ----------------
   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Cycle count and issue count from the timing rules: 1 issue cycle + L wait cycles per
   // issued product, 1 cycle per skipped product, plus the cycle in which OUT is entered.
   function automatic void model_timing(input logic [127:0] a, input logic [127:0] b,
                                        input int lat, output int cyc, output int st);
      logic [63:0] ha, hb;
      bit nz, sk;
      cyc = 1;
      st  = 0;
      for (int p = 0; p < 4; p++) begin
         ha = (p % 2 == 1) ? a[127:64] : a[63:0];
         hb = (p >= 2) ? b[127:64] : b[63:0];
         nz = (ha != 0) && (hb != 0);
         sk = 1'b0;
`ifdef KARA_SKIP_ZERO_EN
         sk = !nz;
`endif
         if (sk) cyc += 1;
         else begin
            cyc += lat + 1;
            st++;
         end
      end
   endfunction

   task automatic do_op(input logic [127:0] xi, input logic [127:0] yi, input int lat, input int drop,
                        output logic [255:0] zo, output logic eo, output int cyc, output int starts);
      int s0;
      mdl_lat  = lat;
      mdl_drop = drop;
      s0       = start_cyc;
      @(posedge clk); #1;
      x = xi;
      y = yi;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      chk("op_done", 256'(out_valid), 256'(1));
      zo     = z;
      eo     = err;
      starts = start_cyc - s0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [127:0] x;
      logic [127:0] y;
      int           lat;
      int           drop;
      logic [255:0] z;
      logic         e;
      int           cyc;
      int           starts;
   } vec_t;

   localparam logic [255:0] Z_ONES  = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_00000000_00000000_00000000_00000001;
   localparam logic [255:0] Z_DROP2 = 256'hFFFFFFFF_FFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_00000001;

   vec_t         tbl[5];
   logic [255:0] zo, zh;
   logic         eo;
   int           cyc, st, ecyc, est, s0, w;
   logic [127:0] rx, ry;
   int           rl;

   initial begin
      #500000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{'1, '1, 3, -1, Z_ONES, 1'b0, 17, 4};
      tbl[2] = '{128'd0, 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321, 3, -1, 256'd0, 1'b0, 17, 4};
`ifdef KARA_SKIP_ZERO_EN
      tbl[1] = '{128'h1_0000000000000002, 128'd3, 3, -1, 256'h3_0000000000000006, 1'b0, 11, 2};
      tbl[2].cyc = 5;
      tbl[2].starts = 0;
      tbl[3] = '{128'd5, 128'd7, 1, -1, 256'd35, 1'b0, 6, 1};
`else
      tbl[1] = '{128'h1_0000000000000002, 128'd3, 3, -1, 256'h3_0000000000000006, 1'b0, 17, 4};
      tbl[3] = '{128'd5, 128'd7, 1, -1, 256'd35, 1'b0, 9, 4};
`endif
      tbl[4] = '{'1, '1, 3, 2, Z_DROP2, 1'b1, -1, 4};

      // reset values
      #1;
      chk("rst_ctl", 256'({in_ready, m_start, out_valid, err, busy}), 256'(5'b10000));
      chk("rst_mab", 256'({m_a, m_b}), 256'd0);
      chk("rst_z", z, 256'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // table vectors
      for (int i = 0; i < 5; i++) begin
         do_op(tbl[i].x, tbl[i].y, tbl[i].lat, tbl[i].drop, zo, eo, cyc, st);
         chk($sformatf("vec%0d_z", i), zo, tbl[i].z);
         chk($sformatf("vec%0d_err", i), 256'(eo), 256'(tbl[i].e));
         if (tbl[i].cyc >= 0) chk($sformatf("vec%0d_lat", i), 256'(cyc), 256'(tbl[i].cyc));
         chk($sformatf("vec%0d_starts", i), 256'(st), 256'(tbl[i].starts));
         @(negedge clk);
         chk($sformatf("vec%0d_single", i), 256'({out_valid, in_ready}), 256'(2'b01));
      end

      // out_ready held low for 10 cycles, spurious m_done while in OUT
      out_ready = 1'b0;
      rx = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
      ry = 128'h0f0f_0f0f_1111_2222_3333_4444_5555_6666;
      do_op(rx, ry, 2, -1, zo, eo, cyc, st);
      chk("hold_z_val", zo, {128'b0, rx} * {128'b0, ry});
      zh = z;
      s0 = start_cyc;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         spur_done = (k == 3);
         @(negedge clk);
         chk($sformatf("hold%0d_z", k), z, zh);
         chk($sformatf("hold%0d_hs", k), 256'({in_ready, out_valid}), 256'(2'b01));
      end
      @(posedge clk); #1;
      spur_done = 1'b0;
      chk("hold_no_start", 256'(start_cyc - s0), 256'd0);
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("accept_in_ready", 256'(in_ready), 256'(1));

      // spurious m_done in IDLE
      @(posedge clk); #1;
      spur_done = 1'b1;
      @(posedge clk); #1;
      spur_done = 1'b0;
      @(negedge clk);
      chk("idle_spur_z", z, zh);
      chk("idle_spur_busy", 256'({busy, out_valid}), 256'd0);

      // reset during WAIT of index 1
      mdl_lat  = 3;
      mdl_drop = -1;
      s0 = start_cyc;
      @(posedge clk); #1;
      x = '1;
      y = '1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      w = 0;
      while ((start_cyc - s0) < 2 && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("mid_reached_idx1", 256'((start_cyc - s0) == 2 && busy && !m_start), 256'(1));
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_ctl", 256'({in_ready, m_start, out_valid, err, busy}), 256'(5'b10000));
      chk("mid_rst_mab", 256'({m_a, m_b}), 256'd0);
      chk("mid_rst_z", z, 256'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      do_op(128'd5, 128'd7, 3, -1, zo, eo, cyc, st);
      chk("post_rst_z", zo, 256'd35);
      chk("post_rst_err", 256'(eo), 256'd0);

      // randomized operands against the arithmetic reference
      for (int r = 0; r < 24; r++) begin
         rx = {$urandom, $urandom, $urandom, $urandom};
         ry = {$urandom, $urandom, $urandom, $urandom};
         if ($urandom_range(0, 3) == 0) rx[127:64] = '0;
         if ($urandom_range(0, 3) == 0) rx[63:0] = '0;
         if ($urandom_range(0, 3) == 0) ry[127:64] = '0;
         if ($urandom_range(0, 3) == 0) ry[63:0] = '0;
         rl = $urandom_range(1, 6);
         model_timing(rx, ry, rl, ecyc, est);
         do_op(rx, ry, rl, -1, zo, eo, cyc, st);
         chk($sformatf("rnd%0d_z", r), zo, {128'b0, rx} * {128'b0, ry});
         chk($sformatf("rnd%0d_err", r), 256'(eo), 256'd0);
         chk($sformatf("rnd%0d_lat", r), 256'(cyc), 256'(ecyc));
         chk($sformatf("rnd%0d_starts", r), 256'(st), 256'(est));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
